binary_up_down_counter: RTL and testbench



---
 rtl/binary_up_down_counter.sv | 49 ++++
 tb/tb_binary_up_down_counter.sv | 119 +++++++++++
 2 files changed

// File: rtl/binary_up_down_counter.sv
// binary_up_down_counter: loadable modulo/saturating up/down counter with terminal-count flag
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, forces O to 0
//   sync_reset synchronous clear (highest synchronous priority)
//   load       synchronous parallel load of N
//   count      count enable
//   up_down    direction: 1 up, 0 down (ignored while count=0)
//   N          parallel load value
//   O          registered counter value
//   tc         combinational terminal count: this edge would wrap (or saturate)
//
// Build option: define UDC_SATURATE_EN to hold at the boundary instead of wrapping.
module binary_up_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_reset,
    input  logic             load,
    input  logic             count,
    input  logic             up_down,
    input  logic [WIDTH-1:0] N,
    output logic [WIDTH-1:0] O,
    output logic             tc
);
    logic [WIDTH-1:0] r_o;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_next;
    logic             w_bound;
    // counting further in the current direction would leave the range
    assign w_bound = up_down ? (r_o == {WIDTH{1'b1}}) : (r_o == '0);
`ifdef UDC_SATURATE_EN
    assign w_step = w_bound ? r_o : (up_down ? r_o + 1'b1 : r_o - 1'b1);
`else
    assign w_step = up_down ? r_o + 1'b1 : r_o - 1'b1;
`endif
    always_comb begin
        w_next = sync_reset ? '0 : load ? N : count ? w_step : r_o;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_o <= '0;
        else        r_o <= w_next;
    end
    assign O  = r_o;
    // rst_n gating keeps tc low during reset even when O=0 and counting down
    assign tc = rst_n & count & ~load & ~sync_reset & w_bound;
endmodule

// File: tb/tb_binary_up_down_counter.sv
// tb_binary_up_down_counter: randomized + directed check of 4- and 8-bit counters against an arithmetic model
module tb_binary_up_down_counter;
`ifdef UDC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic       clk = 1'b0, rst_n = 1'b1, sync_reset = 1'b0, load = 1'b0, count = 1'b0, up_down = 1'b0;
    logic [3:0] n4 = '0, o4;
    logic [7:0] n8 = '0, o8;
    logic       tc4, tc8;
    int         m4 = 0, m8 = 0;
    int         n_tests = 0, n_fail = 0;

    binary_up_down_counter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .sync_reset(sync_reset), .load(load), .count(count),
        .up_down(up_down), .N(n4), .O(o4), .tc(tc4)
    );
    binary_up_down_counter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .sync_reset(sync_reset), .load(load), .count(count),
        .up_down(up_down), .N(n8), .O(o8), .tc(tc8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_next(int m, int w, bit sr, bit ld, bit cnt, bit ud, int n);
        int span = 1 << w;
        int t;
        if (sr) return 0;
        if (ld) return n % span;
        if (!cnt) return m;
        t = ud ? m + 1 : m - 1;
        if (SAT) return (t < 0) ? 0 : (t >= span) ? span - 1 : t;
        return (t + span) % span;
    endfunction

    function automatic bit model_tc(int m, int w, bit sr, bit ld, bit cnt, bit ud);
        int t = ud ? m + 1 : m - 1;
        return cnt && !ld && !sr && (t < 0 || t >= (1 << w));
    endfunction

    task automatic step(input bit sr, input bit ld, input bit cnt, input bit ud, input logic [7:0] n);
        @(negedge clk);
        sync_reset = sr; load = ld; count = cnt; up_down = ud; n8 = n; n4 = n[3:0];
        #1;
        check("tc4", tc4, model_tc(m4, 4, sr, ld, cnt, ud));
        check("tc8", tc8, model_tc(m8, 8, sr, ld, cnt, ud));
        @(posedge clk);
        m4 = model_next(m4, 4, sr, ld, cnt, ud, int'(n[3:0]));
        m8 = model_next(m8, 8, sr, ld, cnt, ud, int'(n));
        #1;
        check("o4", o4, m4);
        check("o8", o8, m8);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_o4", o4, 0);
        check("rst_o8", o8, 0);
        check("rst_tc4", tc4, 0);
        @(negedge clk) rst_n = 1'b1;
        step(0, 1, 0, 0, 8'h07);
        check("load7", o4, 7);
        // async reset mid-cycle with a down-count pending at O=0 afterwards
        @(negedge clk);
        count = 1'b1; up_down = 1'b0; load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_o4", o4, 0);
        check("async_o8", o8, 0);
        check("async_tc4", tc4, 0);
        @(posedge clk);
        #1;
        check("hold_o4", o4, 0);
        check("hold_tc8", tc8, 0);
        @(negedge clk);
        count = 1'b0;
        rst_n = 1'b1;
        m4 = 0; m8 = 0;
        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 1, 1, 8'h00);
        check("sr_hold", o4, 0);
        step(0, 1, 0, 0, 8'h05);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'h09);
        check("down_to0", o4, 0);
        step(0, 1, 0, 0, 8'h09);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 8'h00);
        check("up_to15", o4, 15);
        step(0, 0, 1, 1, 8'h00);
        check("wrap_up", o4, SAT ? 15 : 0);
        step(1, 0, 0, 0, 8'h00);
        step(0, 0, 1, 0, 8'h00);
        check("wrap_down", o4, SAT ? 0 : 15);
        step(0, 1, 1, 1, 8'h03);
        check("load_beats_cnt", o4, 3);
        step(1, 1, 0, 0, 8'h06);
        check("clr_beats_load", o4, 0);
        step(0, 1, 0, 0, 8'h0A);
        for (int i = 0; i < 4; i++) step(0, 0, 0, i[0], 8'h00);
        check("idle_hold", o4, 10);
        step(0, 1, 0, 0, 8'hFE);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 8'h00);
        check("w8_wrap", o8, SAT ? 8'hFF : 8'h01);
        for (int i = 0; i < 400; i++)
            step($urandom_range(15) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
                 $urandom_range(1) == 1, 8'($urandom));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
